// File: rtl/core_pkg.sv
// core_pkg: constants shared by the RV32I pipeline stages.
//   WB_SEL_*  : writeback source select encodings.
//   LOAD_*    : funct3 encodings of the RV32I load instructions.
package core_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// load_align: purely combinational load data extraction.
// Ports:
//   word   in  32  raw aligned word from data memory
//   addr   in  2   effective address low bits
//   funct3 in  3   load type
//   data   out 32  extracted and sign/zero-extended value (little-endian)
//   fault  out 1   misaligned access or illegal funct3
module load_align
    import core_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        fault
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr)
            2'b00: byte_sel = word[7:0];
            2'b01: byte_sel = word[15:8];
            2'b10: byte_sel = word[23:16];
            2'b11: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // Halfword lane chosen by addr[1]; addr[0] only matters for the fault.
        half_sel = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data  = '0;
        fault = 1'b0;
        case (funct3)
            LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: data = {24'd0, byte_sel};
            LOAD_LH: begin
                data  = {{16{half_sel[15]}}, half_sel};
                fault = addr[0];
            end
            LOAD_LHU: begin
                data  = {16'd0, half_sel};
                fault = addr[0];
            end
            LOAD_LW: begin
                data  = word;
                fault = (addr != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register and writeback logic.
// Ports:
//   clk, reset_n             clock; asynchronous active-low reset
//   mem_*                    MEM-stage instruction fields, captured on posedge
//   stall, flush             hold the WB register / load a bubble (flush wins)
//   write_register,
//   write_data, RegWrite     register file write port
//   wb_valid                 WB register holds a real instruction
//   load_fault               held load is misaligned or has an illegal funct3
//   instret                  retired-instruction counter (wraps)
// All outputs are derived from registered state only.
module writeback_stage
    import core_pkg::*;
#(
    parameter int unsigned INSTRET_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mem_valid,
    input  logic [4:0]               mem_rd,
    input  logic                     mem_reg_write,
    input  logic [1:0]               mem_wb_sel,
    input  logic [31:0]              mem_alu_result,
    input  logic [31:0]              mem_pc_plus4,
    input  logic [31:0]              mem_load_data,
    input  logic [2:0]               mem_funct3,
    input  logic                     stall,
    input  logic                     flush,
    output logic [4:0]               write_register,
    output logic [31:0]              write_data,
    output logic                     RegWrite,
    output logic                     wb_valid,
    output logic                     load_fault,
    output logic [INSTRET_WIDTH-1:0] instret
);

    logic [4:0]  rd_q;
    logic        reg_write_q;
    logic [1:0]  wb_sel_q;
    logic [31:0] alu_q;
    logic [31:0] pc4_q;
    logic [31:0] load_q;
    logic [2:0]  funct3_q;

    logic [31:0] la_data;
    logic        la_fault;
    logic        retire;

    load_align u_load_align (
        .word   (load_q),
        .addr   (alu_q[1:0]),
        .funct3 (funct3_q),
        .data   (la_data),
        .fault  (la_fault)
    );

    // The held entry retires when it leaves: normal advance or a flush
    // (flush overrides a simultaneous stall). Faulted loads never retire.
    assign retire = wb_valid && (flush || !stall) && !load_fault;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid    <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= '0;
            alu_q       <= '0;
            pc4_q       <= '0;
            load_q      <= '0;
            funct3_q    <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (!stall) begin
            wb_valid    <= mem_valid;
            rd_q        <= mem_rd;
            reg_write_q <= mem_reg_write;
            wb_sel_q    <= mem_wb_sel;
            alu_q       <= mem_alu_result;
            pc4_q       <= mem_pc_plus4;
            load_q      <= mem_load_data;
            funct3_q    <= mem_funct3;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        load_fault = wb_valid && (wb_sel_q == WB_SEL_LOAD) && la_fault;
        case (wb_sel_q)
            WB_SEL_ALU:  write_data = alu_q;
            WB_SEL_LOAD: write_data = load_fault ? '0 : la_data;
            WB_SEL_PC4:  write_data = pc4_q;
            default:     write_data = alu_q;
        endcase
        write_register = wb_valid ? rd_q : '0;
        RegWrite       = wb_valid && reg_write_q && (rd_q != 5'd0) && !load_fault;
    end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk;
    logic        reset_n;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_pc_plus4;
    logic [31:0] mem_load_data;
    logic [2:0]  mem_funct3;
    logic        stall;
    logic        flush;

    logic [4:0]  write_register, s_write_register;
    logic [31:0] write_data, s_write_data;
    logic        RegWrite, s_RegWrite;
    logic        wb_valid, s_wb_valid;
    logic        load_fault, s_load_fault;
    logic [63:0] instret;
    logic [3:0]  s_instret;

    int checks = 0;
    int failures = 0;

    writeback_stage #(.INSTRET_WIDTH(64)) dut (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel),
        .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
        .mem_load_data(mem_load_data), .mem_funct3(mem_funct3),
        .stall(stall), .flush(flush), .write_register(write_register),
        .write_data(write_data), .RegWrite(RegWrite), .wb_valid(wb_valid),
        .load_fault(load_fault), .instret(instret)
    );

    // Narrow counter instance sharing the same stimulus, for wrap behaviour.
    writeback_stage #(.INSTRET_WIDTH(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .mem_valid(mem_valid), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel),
        .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
        .mem_load_data(mem_load_data), .mem_funct3(mem_funct3),
        .stall(stall), .flush(flush), .write_register(s_write_register),
        .write_data(s_write_data), .RegWrite(s_RegWrite), .wb_valid(s_wb_valid),
        .load_fault(s_load_fault), .instret(s_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        rw;
        logic        lf;
        logic [63:0] ir;
    } exp_t;

    exp_t q[$];

    // Reference model state: the entry currently held in WB.
    logic        m_valid;
    exp_t        m_entry;
    logic [63:0] mi;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                                   input logic [31:0] alu, input logic [31:0] pc4,
                                   input logic [31:0] ld, input logic [2:0] f3);
        exp_t e;
        int unsigned a;
        logic [31:0] b, h;
        a = alu[1:0];
        b = (ld >> (8 * a)) & 32'hFF;
        h = (ld >> (16 * (a / 2))) & 32'hFFFF;
        e.lf = 1'b0;
        e.wd = alu;
        if (sel == 2'd1) begin
            case (f3)
                3'd0: e.wd = (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
                3'd4: e.wd = b;
                3'd1: begin e.wd = (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h; e.lf = (a % 2) != 0; end
                3'd5: begin e.wd = h; e.lf = (a % 2) != 0; end
                3'd2: begin e.wd = ld; e.lf = (a != 0); end
                default: e.lf = 1'b1;
            endcase
            if (e.lf) e.wd = 32'd0;
        end else if (sel == 2'd2) begin
            e.wd = pc4;
        end
        e.wr = rd;
        e.rw = rw && (rd != 5'd0) && !e.lf;
        e.ir = 64'd0;
        return e;
    endfunction

    // Drives one cycle of MEM inputs; after the edge updates the model and
    // pushes the expected response for the entry WB now holds.
    task automatic issue(input logic v, input logic [4:0] rd, input logic rw,
                         input logic [1:0] sel, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] ld,
                         input logic [2:0] f3, input logic st, input logic fl);
        mem_valid = v; mem_rd = rd; mem_reg_write = rw; mem_wb_sel = sel;
        mem_alu_result = alu; mem_pc_plus4 = pc4; mem_load_data = ld;
        mem_funct3 = f3; stall = st; flush = fl;
        @(posedge clk);
        if (m_valid && (fl || !st) && !m_entry.lf) mi = mi + 64'd1;
        if (fl) m_valid = 1'b0;
        else if (!st) begin
            m_valid = v;
            m_entry = model(rd, rw, sel, alu, pc4, ld, f3);
        end
        #1;
        if (m_valid) begin
            m_entry.ir = mi;
            q.push_back(m_entry);
        end
    endtask

    task automatic idle(input logic st, input logic fl);
        issue(1'b0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0, st, fl);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".wb_valid"}, {63'd0, wb_valid}, 64'd0);
        chk({tag, ".write_register"}, {59'd0, write_register}, 64'd0);
        chk({tag, ".write_data"}, {32'd0, write_data}, 64'd0);
        chk({tag, ".RegWrite"}, {63'd0, RegWrite}, 64'd0);
        chk({tag, ".load_fault"}, {63'd0, load_fault}, 64'd0);
        chk({tag, ".instret"}, instret, 64'd0);
        chk({tag, ".instret_small"}, {60'd0, s_instret}, 64'd0);
    endtask

    // Asserts reset between clock edges and checks outputs clear before any edge.
    task automatic reset_mid_cycle();
        #2 reset_n = 1'b0;
        #1 check_reset_state("async_reset");
        q.delete();
        m_valid = 1'b0;
        m_entry.lf = 1'b0;
        mi = 64'd0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Monitor: compares whenever WB presents a valid entry.
    always @(negedge clk) begin
        if (reset_n) begin
            if (wb_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("write_register", {59'd0, write_register}, {59'd0, e.wr});
                    chk("write_data", {32'd0, write_data}, {32'd0, e.wd});
                    chk("RegWrite", {63'd0, RegWrite}, {63'd0, e.rw});
                    chk("load_fault", {63'd0, load_fault}, {63'd0, e.lf});
                    chk("instret", instret, e.ir);
                    chk("instret_small", {60'd0, s_instret}, {60'd0, e.ir[3:0]});
                end
            end else begin
                chk("idle_RegWrite", {63'd0, RegWrite}, 64'd0);
                chk("idle_write_register", {59'd0, write_register}, 64'd0);
                chk("idle_load_fault", {63'd0, load_fault}, 64'd0);
                chk("idle_instret", instret, mi);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ir_before;
        m_valid = 1'b0;
        m_entry = '{default: '0};
        mi = 64'd0;
        reset_n = 1'b0;
        mem_valid = 0; mem_rd = 0; mem_reg_write = 0; mem_wb_sel = 0;
        mem_alu_result = 0; mem_pc_plus4 = 0; mem_load_data = 0; mem_funct3 = 0;
        stall = 0; flush = 0;
        #3 check_reset_state("reset");
        @(posedge clk); #1 reset_n = 1'b1;

        // Load sweep on 0x80F17F22.
        issue(1, 5'd3, 1, 2'd1, 32'h1000_0001, 0, 32'h80F1_7F22, 3'd0, 0, 0);
        issue(1, 5'd4, 1, 2'd1, 32'h1000_0001, 0, 32'h80F1_7F22, 3'd4, 0, 0);
        issue(1, 5'd5, 1, 2'd1, 32'h1000_0003, 0, 32'h80F1_7F22, 3'd0, 0, 0);
        issue(1, 5'd6, 1, 2'd1, 32'h1000_0002, 0, 32'h80F1_7F22, 3'd1, 0, 0);
        issue(1, 5'd7, 1, 2'd1, 32'h1000_0002, 0, 32'h80F1_7F22, 3'd5, 0, 0);
        issue(1, 5'd8, 1, 2'd1, 32'h1000_0000, 0, 32'h80F1_7F22, 3'd2, 0, 0);
        #1 chk("lw_direct", {32'd0, write_data}, 64'h80F1_7F22);
        // Faults: misaligned LW, illegal funct3, misaligned LH.
        issue(1, 5'd9, 1, 2'd1, 32'h1000_0002, 0, 32'h80F1_7F22, 3'd2, 0, 0);
        ir_before = instret;
        issue(1, 5'd10, 1, 2'd1, 32'h1000_0000, 0, 32'h80F1_7F22, 3'd3, 0, 0);
        #1 chk("fault_not_counted", instret, ir_before);
        issue(1, 5'd11, 1, 2'd1, 32'h1000_0001, 0, 32'h80F1_7F22, 3'd1, 0, 0);
        // PC+4 source, reserved select, x0 destination.
        issue(1, 5'd1, 1, 2'd2, 32'hDEAD_BEEF, 32'h0000_0104, 0, 3'd0, 0, 0);
        #1 chk("pc4_direct", {32'd0, write_data}, 64'h104);
        issue(1, 5'd12, 1, 2'd3, 32'h1234_5678, 32'h4, 0, 3'd0, 0, 0);
        issue(1, 5'd0, 1, 2'd0, 32'h0000_00AA, 0, 0, 3'd0, 0, 0);
        // Stall: entry held three cycles, then leaves.
        issue(1, 5'd13, 1, 2'd0, 32'h0BAD_F00D, 0, 0, 3'd0, 0, 0);
        issue(1, 5'd14, 1, 2'd0, 32'h1111_1111, 0, 0, 3'd0, 1, 0);
        issue(1, 5'd14, 1, 2'd0, 32'h1111_1111, 0, 0, 3'd0, 1, 0);
        issue(1, 5'd14, 1, 2'd0, 32'h1111_1111, 0, 0, 3'd0, 0, 0);
        // Flush with stall on the same edge.
        issue(1, 5'd15, 1, 2'd0, 32'h2222_2222, 0, 0, 3'd0, 1, 1);
        #1 chk("flush_wb_valid", {63'd0, wb_valid}, 64'd0);
        idle(0, 0);

        // Reset mid-stall with a valid entry in WB.
        issue(1, 5'd16, 1, 2'd0, 32'h3333_3333, 0, 0, 3'd0, 0, 0);
        stall = 1'b1;
        reset_mid_cycle();
        stall = 1'b0;

        // Wrap on the 4-bit instance: 17 retirements.
        for (int i = 0; i < 17; i++)
            issue(1, 5'($urandom_range(1, 31)), 1, 2'd0, $urandom, 0, 0, 3'd0, 0, 0);
        idle(0, 0);
        #1 chk("wrap_small", {60'd0, s_instret}, 64'd1);
        chk("wrap_wide", instret, 64'd17);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(0, 3) != 0, 5'($urandom), 1'($urandom),
                  2'($urandom), $urandom, $urandom, $urandom, 3'($urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end
        idle(0, 0);
        idle(0, 0);
        @(negedge clk); #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("final_instret", instret, mi);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
